// File: rtl/gobang_pkg.sv
// Shared constants and types for the gobang move picker and its row/col stepper.
package gobang_pkg;

    localparam int BOARD_N     = 15;
    localparam int SCORE_W     = 25;
    localparam int TIMEOUT_CYC = 64;

    localparam int CELLS = BOARD_N * BOARD_N;
    localparam int IDX_W = $clog2(CELLS);
    localparam int RC_W  = $clog2(BOARD_N);
    localparam int TO_W  = $clog2(TIMEOUT_CYC + 1);

    typedef logic [SCORE_W-1:0] score_t;
    typedef logic [RC_W-1:0]    coord_t;

    typedef struct packed {
        coord_t row;
        coord_t col;
    } pos_t;

    typedef enum logic [2:0] {
        IDLE,
        SCAN,
        REQ,
        WAIT,
        CMP,
        FIN
    } picker_state_e;

endpackage

// File: rtl/gobang_move_picker_if.sv
// Request/response handshake between the move picker (master) and the Score engine (slave).
interface gobang_move_picker_if;
    import gobang_pkg::*;

    logic   start;
    coord_t row;
    coord_t col;
    logic   valid;
    score_t score;

    modport master (output start, output row, output col, input  valid, input  score);
    modport slave  (input  start, input  row, input  col, output valid, output score);

endinterface

// File: rtl/gobang_rc_counter.sv
// Row-major cell stepper: linear index plus a divide-free row/col pair.
module gobang_rc_counter
    import gobang_pkg::*;
(
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_clr,
    input  logic             i_inc,
    output pos_t             o_pos,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_last
);

    pos_t             pos_q;
    logic [IDX_W-1:0] idx_q;

    // Advance one cell per inc; clear has priority; col wraps into the next row
    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr) begin
            pos_q <= '0;
            idx_q <= '0;
        end else if (i_inc) begin
            idx_q <= idx_q + 1'b1;
            if (pos_q.col == coord_t'(BOARD_N - 1)) begin
                pos_q.col <= '0;
                pos_q.row <= pos_q.row + 1'b1;
            end else begin
                pos_q.col <= pos_q.col + 1'b1;
            end
        end
    end

    assign o_pos  = pos_q;
    assign o_idx  = idx_q;
    assign o_last = (idx_q == IDX_W'(CELLS - 1));

endmodule

// File: rtl/gobang_move_picker.sv
// Gobang AI move picker: scans every empty cell, asks the Score engine for each one
// and keeps the best (highest, earliest on ties) as the move to play.
// Optional build macro SCORE_TIMEOUT_EN: bounds the wait for a score and adds o_timeout.
//
//  state | meaning
//  IDLE  | waiting for i_start
//  SCAN  | test current cell; occupied cells step on, empty cells request a score
//  REQ   | o_score_start high for this one cycle
//  WAIT  | waiting for i_score_valid (or the timeout, when built in)
//  CMP   | fold the captured score into the running best, step to next cell
//  FIN   | o_done pulse, result outputs final
module gobang_move_picker
    import gobang_pkg::*;
(
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_start,
    input  logic [CELLS-1:0]      i_occupied,
    gobang_move_picker_if.master  score_if,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_move_valid,
    output coord_t                o_move_row,
    output coord_t                o_move_col,
    output score_t                o_best_score
`ifdef SCORE_TIMEOUT_EN
    ,
    output logic                  o_timeout
`endif
);

    picker_state_e    state_q;
    logic             busy_q;
    logic             done_q;
    logic             score_start_q;
    logic             move_valid_q;
    pos_t             move_pos_q;
    score_t           best_q;
    score_t           score_q;

    pos_t             rc_pos;
    logic [IDX_W-1:0] rc_idx;
    logic             rc_last;
    logic             rc_clr;
    logic             rc_inc;
    logic             cell_occ;
    logic             wait_expire;

`ifdef SCORE_TIMEOUT_EN
    logic [TO_W-1:0]  wait_cnt_q;
    logic             timeout_q;

    assign wait_expire = (state_q == WAIT) && !score_if.valid && (wait_cnt_q == '0);
    assign o_timeout   = timeout_q;
`else
    assign wait_expire = 1'b0;
`endif

    assign cell_occ = i_occupied[rc_idx];
    assign rc_clr   = (state_q == IDLE) && i_start;
    assign rc_inc   = !rc_last && (((state_q == SCAN) && cell_occ) || (state_q == CMP) || wait_expire);

    gobang_rc_counter u_rc (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_clr  (rc_clr),
        .i_inc  (rc_inc),
        .o_pos  (rc_pos),
        .o_idx  (rc_idx),
        .o_last (rc_last)
    );

    // Search sequencer with registered handshake, status and result outputs
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q       <= IDLE;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            score_start_q <= 1'b0;
            move_valid_q  <= 1'b0;
            move_pos_q    <= '0;
            best_q        <= '0;
            score_q       <= '0;
`ifdef SCORE_TIMEOUT_EN
            wait_cnt_q    <= '0;
            timeout_q     <= 1'b0;
`endif
        end else begin
            score_start_q <= 1'b0;
            done_q        <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (i_start) begin
                        state_q      <= SCAN;
                        busy_q       <= 1'b1;
                        move_valid_q <= 1'b0;
                        move_pos_q   <= '0;
                        best_q       <= '0;
`ifdef SCORE_TIMEOUT_EN
                        timeout_q    <= 1'b0;
`endif
                    end
                end
                SCAN: begin
                    if (!cell_occ) begin
                        state_q       <= REQ;
                        score_start_q <= 1'b1;
                    end else if (rc_last) begin
                        state_q <= FIN;
                        done_q  <= 1'b1;
                    end
                end
                REQ: begin
                    state_q <= WAIT;
`ifdef SCORE_TIMEOUT_EN
                    wait_cnt_q <= TO_W'(TIMEOUT_CYC - 1);
`endif
                end
                WAIT: begin
                    if (score_if.valid) begin
                        score_q <= score_if.score;
                        state_q <= CMP;
                    end
`ifdef SCORE_TIMEOUT_EN
                    else if (wait_expire) begin
                        timeout_q <= 1'b1;
                        if (rc_last) begin
                            state_q <= FIN;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= SCAN;
                        end
                    end else begin
                        wait_cnt_q <= wait_cnt_q - 1'b1;
                    end
`endif
                end
                CMP: begin
                    // Strictly greater keeps the earlier cell on ties; first candidate always wins
                    if (!move_valid_q || (score_q > best_q)) begin
                        move_valid_q <= 1'b1;
                        move_pos_q   <= rc_pos;
                        best_q       <= score_q;
                    end
                    if (rc_last) begin
                        state_q <= FIN;
                        done_q  <= 1'b1;
                    end else begin
                        state_q <= SCAN;
                    end
                end
                FIN: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign score_if.start = score_start_q;
    assign score_if.row   = rc_pos.row;
    assign score_if.col   = rc_pos.col;

    assign o_busy       = busy_q;
    assign o_done       = done_q;
    assign o_move_valid = move_valid_q;
    assign o_move_row   = move_pos_q.row;
    assign o_move_col   = move_pos_q.col;
    assign o_best_score = best_q;

endmodule
